video_pll_reset_sequencer: RTL
==============================

VIDEO_PLL_RESET_SEQUENCER -- requirements
Module: video_pll_reset_sequencer

Interface
REQ-001 SHALL provide parameter PLL_RST_CYCLES, default 16, cycles pll_rst is held per PLL reset pulse (min 1).
REQ-002 SHALL provide parameter LOCK_FILTER_CYCLES, default 1024, consecutive synchronized-lock cycles required before lock is declared (min 1).
REQ-003 SHALL provide parameter LOCK_TIMEOUT_CYCLES, default 1000000, WAIT_LOCK cycles allowed before a lock timeout.
REQ-004 SHALL provide parameter STAGGER_CYCLES, default 8, spacing between successive domain reset releases (min 1).
REQ-005 clk  in  1  single system clock (50 MHz PLL reference domain).
REQ-006 reset_n  in  1  reset; synchronous, active-low.
REQ-007 pll_locked  in  1  PLL locked indication, asynchronous to clk.
REQ-008 soft_reset  in  1  one-cycle request to re-run the full PLL reset sequence.
REQ-009 err_clear  in  1  one-cycle clear of timeout_err.
REQ-010 pll_rst  out  1  active-high reset to the video PLL.
REQ-011 domain_reset_n  out  3  active-low resets for outclk_0, outclk_1, outclk_2 consumers.
REQ-012 pll_ready  out  1  high only in RUN.
REQ-013 relock_count  out  8  saturating count of lock losses seen in RUN.
REQ-014 timeout_err  out  1  sticky lock-timeout flag.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value lock_s.
REQ-016 FSM states SHALL be PLL_RST, WAIT_LOCK, RELEASE, RUN.
REQ-017 PLL_RST: pll_rst=1, domain_reset_n=3'b000; after exactly PLL_RST_CYCLES cycles go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; filter counter increments while lock_s=1, clears to 0 on any lock_s=0 cycle.
REQ-019 WAIT_LOCK: when filter counter reaches LOCK_FILTER_CYCLES go to RELEASE, timeout counter cleared.
REQ-020 WAIT_LOCK: if LOCK_TIMEOUT_CYCLES elapse without lock declared, set timeout_err and go to PLL_RST.
REQ-021 RELEASE: domain_reset_n[0] deasserts on entry cycle +STAGGER_CYCLES, [1] at +2*STAGGER_CYCLES, [2] at +3*STAGGER_CYCLES; next cycle enter RUN.
REQ-022 RELEASE: lock_s=0 on any cycle SHALL abort to PLL_RST (all domain resets reasserted next cycle); relock_count unchanged.
REQ-023 RUN: pll_ready=1, domain_reset_n=3'b111; lock_s=0 for one cycle SHALL go to PLL_RST and increment relock_count.
REQ-024 relock_count SHALL saturate at 255, never wrap.
REQ-025 soft_reset=1 in any state SHALL force PLL_RST next cycle, restarting its counter; not counted as lock loss; soft_reset wins over simultaneous lock loss (no increment).
REQ-026 timeout_err cleared by err_clear; if err_clear and a new timeout coincide, set wins.
REQ-027 Domain resets SHALL reassert simultaneously and release only in ascending index order.
REQ-028 All outputs registered; no combinational path input to output.

Reset
REQ-029 On reset_n=0 at a clk edge: state=PLL_RST, all counters 0, synchronizer flops 0, pll_rst=1, domain_reset_n=3'b000, pll_ready=0, relock_count=0, timeout_err=0.
REQ-030 Reset asserted mid-sequence SHALL take effect the following edge regardless of state; PLL_RST_CYCLES count restarts after reset_n returns high.

Structure
REQ-031 State encoding and counter width helper constants SHALL live in shared package video_pll_ctrl_pkg.
REQ-032 The 2-flop synchronizer SHALL be a separate sub-module, bit_sync2.
REQ-033 Counter widths SHALL be derived from parameters via $clog2; one shared cycle counter reused across PLL_RST/RELEASE permitted.

Verification
REQ-034 Params 4/8/100/2; reset release, pll_locked high at cycle 10 -> pll_rst high exactly 4 cycles, domain_reset_n goes 001,011,111 two cycles apart, pll_ready=1.
REQ-035 pll_locked glitches low 1 cycle at filter count 5 -> filter restarts; lock declared 8 cycles after glitch ends (+sync latency).
REQ-036 pll_locked never high -> timeout_err=1 after 100 WAIT_LOCK cycles, pll_rst re-pulses 4 cycles; err_clear -> timeout_err=0.
REQ-037 In RUN drop pll_locked 300 times -> relock_count=255, each drop reasserts domain_reset_n=000 within 3 cycles.
REQ-038 soft_reset in RUN coincident with lock loss -> PLL_RST, relock_count unchanged; reset_n low during RELEASE -> all outputs at reset values next edge.

Source files
------------

// File: rtl/video_pll_ctrl_pkg.sv
// Shared types and width helpers for the video PLL reset sequencer.
// Holds the FSM state encoding and counter sizing function.
package video_pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  localparam int         DOMAINS    = 3;
  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  // Bits needed to hold values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/video_pll_reset_sequencer_if.sv
// Control/status bus of the PLL reset sequencer.
// master: soft_reset/err_clear out; slave: status out.
interface video_pll_reset_sequencer_if;

  logic       soft_reset;
  logic       err_clear;
  logic       pll_ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  modport master (
    output soft_reset,
    output err_clear,
    input  pll_ready,
    input  relock_count,
    input  timeout_err
  );

  modport slave (
    input  soft_reset,
    input  err_clear,
    output pll_ready,
    output relock_count,
    output timeout_err
  );

endinterface

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk, reset_n (sync, active-low), d in, q out.
module bit_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_pll_reset_sequencer.sv
// Video PLL reset pulse, lock filter/timeout and staggered domain release.
// Ports: clk, reset_n, pll_locked, ctl bus, pll_rst, domain_reset_n[2:0].
module video_pll_reset_sequencer
  import video_pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int STAGGER_CYCLES      = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         pll_locked,
  video_pll_reset_sequencer_if.slave   ctl,
  output logic                         pll_rst,
  output logic [DOMAINS-1:0]           domain_reset_n
);

  localparam int REL_N = 3 * STAGGER_CYCLES;
  localparam int CMAX  = (PLL_RST_CYCLES > REL_N) ?
                         PLL_RST_CYCLES : REL_N;
  localparam int CW = cnt_w(CMAX);
  localparam int FW = cnt_w(LOCK_FILTER_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] REL_1    = CW'(STAGGER_CYCLES);
  localparam logic [CW-1:0] REL_2    = CW'(2 * STAGGER_CYCLES);
  localparam logic [CW-1:0] REL_3    = CW'(REL_N);
  localparam logic [FW-1:0] FLT_LAST = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] flt_q, flt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rlk_q, rlk_d;
  logic          err_q, err_d;
  logic [DOMAINS-1:0] dom_d;
  logic          lock_s;

  bit_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flt_d   = '0;
    tmo_d   = '0;
    rlk_d   = rlk_q;
    err_d   = err_q;
    if (ctl.err_clear) err_d = 1'b0;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        flt_d = lock_s ? flt_q + 1'b1 : '0;
        tmo_d = tmo_q + 1'b1;
        // Lock completing on the last allowed cycle beats the timeout.
        if (lock_s && flt_q == FLT_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          flt_d   = '0;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          flt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == REL_3) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          if (rlk_q != RELOCK_MAX) rlk_d = rlk_q + 8'd1;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
    // Soft reset overrides everything, including a lock-loss count.
    if (ctl.soft_reset) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      flt_d   = '0;
      tmo_d   = '0;
      rlk_d   = rlk_q;
    end
  end

  // Outputs are decoded from next state so they flop with the state.
  always_comb begin
    dom_d = '0;
    unique case (state_d)
      RELEASE: dom_d = {cnt_d >= REL_3,
                        cnt_d >= REL_2,
                        cnt_d >= REL_1};
      RUN:     dom_d = '1;
      default: dom_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= PLL_RST;
      cnt_q          <= '0;
      flt_q          <= '0;
      tmo_q          <= '0;
      rlk_q          <= '0;
      err_q          <= 1'b0;
      pll_rst        <= 1'b1;
      domain_reset_n <= '0;
      ctl.pll_ready  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flt_q          <= flt_d;
      tmo_q          <= tmo_d;
      rlk_q          <= rlk_d;
      err_q          <= err_d;
      pll_rst        <= (state_d == PLL_RST);
      domain_reset_n <= dom_d;
      ctl.pll_ready  <= (state_d == RUN);
    end
  end

  assign ctl.relock_count = rlk_q;
  assign ctl.timeout_err  = err_q;

endmodule
